// File: rtl/camera_capture_sequencer.sv
// Still-capture sequencer: wake from power save, align to a frame start, gate one frame,
// launch compression and hold image-ready. All outputs are registered off the current state.
`timescale 1ns/1ps
module camera_capture_sequencer #(
  parameter int unsigned WAKE_CYCLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 16777215
) (
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic start_capture_in,
  input  logic power_save_enable_in,
  input  logic frame_valid_in,
  input  logic compression_done_in,
  output logic sensor_clock_enable_out,
  output logic capture_enable_out,
  output logic compression_start_out,
  output logic image_ready_out,
  output logic busy_out,
  output logic error_out
);

  localparam int unsigned WakeW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWake,
    StSync,
    StCapture,
    StCompress,
    StDone
  } state_e;

  state_e            state_q;
  logic              fv_q;
  logic [WakeW-1:0]  wake_cnt_q;
  logic [TmoW-1:0]   tmo_cnt_q;
  logic              sce_q;
  logic              cap_q;
  logic              comp_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic fv_rise;
  logic fv_fall;
  logic idle_like;
  logic timed;
  logic tmo_hit;
  logic wake_last;
  logic start_ok;

  assign fv_rise   = frame_valid_in & ~fv_q;
  assign fv_fall   = ~frame_valid_in & fv_q;
  assign idle_like = (state_q == StIdle) || (state_q == StDone);
  assign timed     = (state_q == StSync) || (state_q == StCapture) || (state_q == StCompress);
  // Counter stops one short of the limit, so it can never wrap.
  assign tmo_hit   = timed && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
  assign wake_last = (wake_cnt_q == WakeW'(WAKE_CYCLES - 1));
  assign start_ok  = start_capture_in && idle_like;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= StIdle;
      fv_q       <= 1'b0;
      wake_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      sce_q      <= 1'b1;
      cap_q      <= 1'b0;
      comp_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fv_q   <= frame_valid_in;
      sce_q  <= !(power_save_enable_in && idle_like);
      busy_q <= !idle_like;
      cap_q  <= (state_q == StCapture) && !tmo_hit;
      // The first COMPRESS cycle is the only one that still sees capture high.
      comp_q <= (state_q == StCompress) && cap_q && !tmo_hit;

      if (start_ok) begin
        ready_q <= 1'b0;
      end else if (state_q == StDone) begin
        ready_q <= 1'b1;
      end

      if (tmo_hit) begin
        err_q <= 1'b1;
      end else if (start_ok) begin
        err_q <= 1'b0;
      end

      case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            if (power_save_enable_in && (WAKE_CYCLES != 0)) begin
              state_q    <= StWake;
              wake_cnt_q <= '0;
            end else begin
              state_q   <= StSync;
              tmo_cnt_q <= '0;
            end
          end
        end
        StWake: begin
          if (wake_last) begin
            state_q   <= StSync;
            tmo_cnt_q <= '0;
          end else begin
            wake_cnt_q <= wake_cnt_q + WakeW'(1);
          end
        end
        StSync: begin
          if (tmo_hit) begin
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            if (fv_rise) state_q <= StCapture;
          end
        end
        StCapture: begin
          if (tmo_hit) begin
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            if (fv_fall) state_q <= StCompress;
          end
        end
        StCompress: begin
          if (tmo_hit) begin
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            if (compression_done_in) state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sensor_clock_enable_out = sce_q;
  assign capture_enable_out      = cap_q;
  assign compression_start_out   = comp_q;
  assign image_ready_out         = ready_q;
  assign busy_out                = busy_q;
  assign error_out               = err_q;

endmodule
